// File: rtl/buzzer_alarm_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : buzzer_alarm_driver                                           |
// | Purpose  : Generates gated square-wave beeps for the piezo buzzer pin    |
// |            and reports busy/done to the alarm requester.                 |
// | Option   : define BUZZER_RETRIGGER_EN to let alarm_start restart a       |
// |            running sequence.                                             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module buzzer_alarm_driver #(
  parameter int CLK_FREQ    = 50000000,
  parameter int TONE_HZ     = 2000,
  parameter int BEEP_ON_MS  = 200,
  parameter int BEEP_OFF_MS = 200,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alarm_start,
  input  logic [CNT_W-1:0] beep_count,
  input  logic             alarm_stop,
  output logic             buzzer,
  output logic             busy,
  output logic             done
);

  localparam logic [31:0] C_HALF    = 32'(CLK_FREQ / (2 * TONE_HZ));
  localparam logic [31:0] C_ON_CYC  = 32'((CLK_FREQ / 1000) * BEEP_ON_MS);
  localparam logic [31:0] C_OFF_CYC = 32'((CLK_FREQ / 1000) * BEEP_OFF_MS);

`ifdef BUZZER_RETRIGGER_EN
  localparam logic C_RETRIG = 1'b1;
`else
  localparam logic C_RETRIG = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TONE = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t           r_state,     w_state_nxt;
  logic             r_buzzer,    w_buzzer_nxt;
  logic             r_busy,      w_busy_nxt;
  logic             r_done,      w_done_nxt;
  logic [31:0]      r_tone_cnt,  w_tone_cnt_nxt;
  logic [31:0]      r_phase_cnt, w_phase_cnt_nxt;
  logic [31:0]      r_beeps,     w_beeps_nxt;
  logic [CNT_W-1:0] r_count,     w_count_nxt;

  logic        w_restart;
  logic        w_tone_wrap;
  logic        w_on_end;
  logic        w_off_end;
  logic        w_last_beep;
  logic [31:0] w_beeps_inc;

  assign w_restart   = alarm_start && !alarm_stop && ((r_state == S_IDLE) || C_RETRIG);
  assign w_tone_wrap = (r_tone_cnt == C_HALF - 32'd1);
  assign w_on_end    = (r_phase_cnt == C_ON_CYC - 32'd1);
  assign w_off_end   = (r_phase_cnt == C_OFF_CYC - 32'd1);
  assign w_beeps_inc = r_beeps + 32'd1;
  // count==0 means continuous, so the last-beep test only applies to a nonzero count
  assign w_last_beep = (r_count != '0) && (w_beeps_inc == 32'(r_count));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_buzzer    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_tone_cnt  <= '0;
      r_phase_cnt <= '0;
      r_beeps     <= '0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_buzzer    <= w_buzzer_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_tone_cnt  <= w_tone_cnt_nxt;
      r_phase_cnt <= w_phase_cnt_nxt;
      r_beeps     <= w_beeps_nxt;
      r_count     <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_buzzer_nxt    = r_buzzer;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_tone_cnt_nxt  = r_tone_cnt;
    w_phase_cnt_nxt = r_phase_cnt;
    w_beeps_nxt     = r_beeps;
    w_count_nxt     = r_count;

    if (r_state != S_IDLE && alarm_stop) begin
      w_state_nxt  = S_IDLE;
      w_buzzer_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
      w_done_nxt   = 1'b1;
    end else if (w_restart) begin
      // A retrigger abandons the old sequence silently: no done pulse
      w_state_nxt     = S_TONE;
      w_count_nxt     = beep_count;
      w_busy_nxt      = 1'b1;
      w_buzzer_nxt    = 1'b1;
      w_tone_cnt_nxt  = '0;
      w_phase_cnt_nxt = '0;
      w_beeps_nxt     = '0;
    end else begin
      case (r_state)
        S_TONE: begin
          w_phase_cnt_nxt = r_phase_cnt + 32'd1;
          if (w_tone_wrap) begin
            w_tone_cnt_nxt = '0;
            w_buzzer_nxt   = ~r_buzzer;
          end else begin
            w_tone_cnt_nxt = r_tone_cnt + 32'd1;
          end
          if (w_on_end) begin
            w_buzzer_nxt = 1'b0;
            w_beeps_nxt  = (&r_beeps) ? r_beeps : w_beeps_inc;
            if (w_last_beep) begin
              w_state_nxt = S_IDLE;
              w_busy_nxt  = 1'b0;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt     = S_GAP;
              w_phase_cnt_nxt = '0;
            end
          end
        end
        S_GAP: begin
          w_buzzer_nxt    = 1'b0;
          w_phase_cnt_nxt = r_phase_cnt + 32'd1;
          if (w_off_end) begin
            w_state_nxt     = S_TONE;
            w_buzzer_nxt    = 1'b1;
            w_tone_cnt_nxt  = '0;
            w_phase_cnt_nxt = '0;
          end
        end
        S_IDLE: begin
          w_buzzer_nxt = 1'b0;
          w_busy_nxt   = 1'b0;
        end
        default: begin
          w_state_nxt  = S_IDLE;
          w_buzzer_nxt = 1'b0;
          w_busy_nxt   = 1'b0;
        end
      endcase
    end
  end

  assign buzzer = r_buzzer;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_buzzer_alarm_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_buzzer_alarm_driver                                        |
// | Purpose  : Scoreboard bench for buzzer_alarm_driver (HALF=5, ON=20,      |
// |            OFF=10); honours BUZZER_RETRIGGER_EN when defined.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_buzzer_alarm_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       alarm_start = 1'b0;
  logic [3:0] beep_count = 4'd0;
  logic       alarm_stop = 1'b0;
  logic       buzzer, busy, done;

  int total = 0;
  int bad   = 0;

  // Expected {buzzer, busy, done} per cycle, sampled on the falling edge
  logic [2:0] sb_q[$];
  logic [2:0] exp_v;

  buzzer_alarm_driver #(
    .CLK_FREQ   (10000),
    .TONE_HZ    (1000),
    .BEEP_ON_MS (2),
    .BEEP_OFF_MS(1),
    .CNT_W      (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .alarm_start(alarm_start),
    .beep_count (beep_count),
    .alarm_stop (alarm_stop),
    .buzzer     (buzzer),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Timeline of a sequence of n beeps (n=0: endless), k cycles after the start edge.
  // Each beep is 20 tone cycles (buzzer 1,0,1,0 in 5-cycle halves) then a 10-cycle gap.
  function automatic logic [2:0] seq_model(input int n, input int k);
    int r;
    int fin;
    fin = 30 * (n - 1) + 20;
    if (n != 0 && k > fin)  return 3'b000;
    if (n != 0 && k == fin) return 3'b001;
    r = k % 30;
    if (r < 20) return {((r / 5) % 2 == 0), 1'b1, 1'b0};
    return 3'b010;
  endfunction

  task automatic issue_start(input logic [3:0] cnt);
    @(negedge clk);
    alarm_start = 1'b1;
    beep_count  = cnt;
    @(negedge clk);
    alarm_start = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    total++;
    if ({buzzer, busy, done} !== 3'b000) begin
      bad++;
      $display("FAIL reset_async got=%b want=000", {buzzer, busy, done});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) sb_q.push_back(3'b000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp_v = sb_q.pop_front();
      total++;
      if ({buzzer, busy, done} !== exp_v) begin
        bad++;
        $display("FAIL reset_idle i=%0d got=%b want=%b", i, {buzzer, busy, done}, exp_v);
      end
    end
  endtask

  task automatic test_count2(input string tag);
    for (int k = 0; k < 56; k++) sb_q.push_back(seq_model(2, k));
    issue_start(4'd2);
    for (int k = 0; k < 56; k++) begin
      exp_v = sb_q.pop_front();
      total++;
      if ({buzzer, busy, done} !== exp_v) begin
        bad++;
        $display("FAIL %s k=%0d got=%b want=%b", tag, k, {buzzer, busy, done}, exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_continuous;
    for (int k = 0; k < 101; k++) sb_q.push_back(seq_model(0, k));
    sb_q.push_back(3'b001);
    for (int k = 0; k < 40; k++) sb_q.push_back(3'b000);
    issue_start(4'd0);
    for (int k = 0; k < 142; k++) begin
      exp_v = sb_q.pop_front();
      total++;
      if ({buzzer, busy, done} !== exp_v) begin
        bad++;
        $display("FAIL continuous k=%0d got=%b want=%b", k, {buzzer, busy, done}, exp_v);
      end
      alarm_stop = (k == 100);
      @(negedge clk);
    end
    alarm_stop = 1'b0;
  endtask

  task automatic test_start_stop_idle;
    for (int k = 0; k < 110; k++) sb_q.push_back(3'b000);
    @(negedge clk);
    alarm_start = 1'b1;
    alarm_stop  = 1'b1;
    beep_count  = 4'd2;
    @(negedge clk);
    alarm_start = 1'b0;
    for (int k = 0; k < 110; k++) begin
      exp_v = sb_q.pop_front();
      total++;
      if ({buzzer, busy, done} !== exp_v) begin
        bad++;
        $display("FAIL start_stop_idle k=%0d got=%b want=%b", k, {buzzer, busy, done}, exp_v);
      end
      alarm_stop = (k >= 100 && k < 104);
      @(negedge clk);
    end
    alarm_stop = 1'b0;
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 100; k++) begin
`ifdef BUZZER_RETRIGGER_EN
      sb_q.push_back(k <= 8 ? seq_model(1, k) : seq_model(3, k - 9));
`else
      sb_q.push_back(seq_model(1, k));
`endif
    end
    issue_start(4'd1);
    for (int k = 0; k < 100; k++) begin
      exp_v = sb_q.pop_front();
      total++;
      if ({buzzer, busy, done} !== exp_v) begin
        bad++;
        $display("FAIL back_to_back k=%0d got=%b want=%b", k, {buzzer, busy, done}, exp_v);
      end
      alarm_start = (k == 8);
      beep_count  = (k == 8) ? 4'd3 : 4'd1;
      @(negedge clk);
    end
    alarm_start = 1'b0;
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 13; k++) sb_q.push_back(seq_model(2, k));
    issue_start(4'd2);
    for (int k = 0; k < 13; k++) begin
      exp_v = sb_q.pop_front();
      total++;
      if ({buzzer, busy, done} !== exp_v) begin
        bad++;
        $display("FAIL reset_mid_pre k=%0d got=%b want=%b", k, {buzzer, busy, done}, exp_v);
      end
      if (k < 12) @(negedge clk);
    end
    #1 reset = 1'b1;
    #1;
    total++;
    if ({buzzer, busy, done} !== 3'b000) begin
      bad++;
      $display("FAIL reset_mid_async got=%b want=000", {buzzer, busy, done});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 25; k++) sb_q.push_back(3'b000);
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      exp_v = sb_q.pop_front();
      total++;
      if ({buzzer, busy, done} !== exp_v) begin
        bad++;
        $display("FAIL reset_mid_idle k=%0d got=%b want=%b", k, {buzzer, busy, done}, exp_v);
      end
    end
    test_count2("reset_mid_restart");
  endtask

  initial begin
    test_reset();
    test_count2("count2");
    test_continuous();
    test_start_stop_idle();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
